// File: rtl/time_counter.sv
// 24-hour BCD clock: prescaler-driven seconds/minutes/hours with an adjust mode
// that sets minutes and hours from edge-detected push-button requests.
module time_counter #(
  parameter int CLK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adj_mode,
  input  logic       hour_en,
  input  logic       min_en,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       tick_1hz,
  output logic       hour_pulse
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] presc;
  logic             hour_p0, hour_p1;
  logic             min_p0, min_p1;
  logic             hour_rise, min_rise;

  function automatic logic bcd_at_max(input logic [7:0] v, input logic [3:0] tens_max,
                                      input logic [3:0] ones_max);
    return (v[7:4] == tens_max) && (v[3:0] == ones_max);
  endfunction

  // Wraps to 00 at the given maximum; each nibble carries at 9 so digits never leave 0..9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] tens_max,
                                         input logic [3:0] ones_max);
    if (bcd_at_max(v, tens_max, ones_max)) return 8'h00;
    else if (v[3:0] == 4'd9)               return {v[7:4] + 4'd1, 4'd0};
    else                                   return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign hour_rise = hour_p0 & ~hour_p1;
  assign min_rise  = min_p0 & ~min_p1;
  assign tick_1hz  = (presc == TERM) && !adj_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      hour_p0    <= 1'b0;
      hour_p1    <= 1'b0;
      min_p0     <= 1'b0;
      min_p1     <= 1'b0;
      hh_bcd     <= 8'h00;
      mm_bcd     <= 8'h00;
      ss_bcd     <= 8'h00;
      hour_pulse <= 1'b0;
    end else begin
      // Stage p0: request sampling; stage p1: previous sample for edge detection
      hour_p0    <= hour_en;
      hour_p1    <= hour_p0;
      min_p0     <= min_en;
      min_p1     <= min_p0;
      hour_pulse <= 1'b0;
      if (adj_mode) begin
        presc  <= '0;
        ss_bcd <= 8'h00;
        if (min_rise)  mm_bcd <= bcd_inc(mm_bcd, 4'd5, 4'd9);
        if (hour_rise) hh_bcd <= bcd_inc(hh_bcd, 4'd2, 4'd3);
      end else begin
        presc <= (presc == TERM) ? '0 : presc + 1'b1;
        if (tick_1hz) begin
          ss_bcd <= bcd_inc(ss_bcd, 4'd5, 4'd9);
          if (bcd_at_max(ss_bcd, 4'd5, 4'd9)) begin
            mm_bcd <= bcd_inc(mm_bcd, 4'd5, 4'd9);
            if (bcd_at_max(mm_bcd, 4'd5, 4'd9)) begin
              hh_bcd     <= bcd_inc(hh_bcd, 4'd2, 4'd3);
              hour_pulse <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter with CLK_DIV=4; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_time_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       adj_mode = 1'b0;
  logic       hour_en = 1'b0;
  logic       min_en = 1'b0;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic       tick_1hz, hour_pulse;
  int         n_cmp = 0;
  int         n_bad = 0;

  time_counter #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .adj_mode(adj_mode), .hour_en(hour_en), .min_en(min_en),
    .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd), .tick_1hz(tick_1hz),
    .hour_pulse(hour_pulse)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; adj_mode = 1'b0; hour_en = 1'b0; min_en = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  // Issue max(h,m) two-cycle pulses; hour_en pulses h times, min_en m times.
  task automatic preset(input int h, input int m);
    for (int i = 0; i < ((h > m) ? h : m); i++) begin
      hour_en = (i < h); min_en = (i < m);
      step(1);
      hour_en = 1'b0; min_en = 1'b0;
      step(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    n_cmp++; if (hh_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_hh: got %h want 00", hh_bcd); end
    n_cmp++; if (mm_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_mm: got %h want 00", mm_bcd); end
    n_cmp++; if (ss_bcd !== 8'h00) begin n_bad++; $display("FAIL reset_ss: got %h want 00", ss_bcd); end
    n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick_1hz); end
    n_cmp++; if (hour_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_hp: got %b want 0", hour_pulse); end
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      n_cmp++;
      if (tick_1hz !== (i == 3)) begin n_bad++; $display("FAIL reset_first_tick[%0d]: got %b want %b", i, tick_1hz, (i == 3)); end
    end
    n_cmp++; if (ss_bcd !== 8'h01) begin n_bad++; $display("FAIL reset_first_ss: got %h want 01", ss_bcd); end
  endtask

  task automatic test_run();
    do_reset();
    for (int i = 1; i <= 240; i++) begin
      step(1);
      n_cmp++;
      if (tick_1hz !== (i % 4 == 3)) begin n_bad++; $display("FAIL run_tick[%0d]: got %b want %b", i, tick_1hz, (i % 4 == 3)); end
      n_cmp++;
      if (hour_pulse !== 1'b0) begin n_bad++; $display("FAIL run_hp[%0d]: got %b want 0", i, hour_pulse); end
      if (i == 4) begin
        n_cmp++; if (ss_bcd !== 8'h01) begin n_bad++; $display("FAIL run_ss1: got %h want 01", ss_bcd); end
      end
      if (i == 236) begin
        n_cmp++; if (ss_bcd !== 8'h59) begin n_bad++; $display("FAIL run_ss59: got %h want 59", ss_bcd); end
        n_cmp++; if (mm_bcd !== 8'h00) begin n_bad++; $display("FAIL run_mm00: got %h want 00", mm_bcd); end
      end
    end
    n_cmp++; if (ss_bcd !== 8'h00) begin n_bad++; $display("FAIL run_ss_wrap: got %h want 00", ss_bcd); end
    n_cmp++; if (mm_bcd !== 8'h01) begin n_bad++; $display("FAIL run_mm01: got %h want 01", mm_bcd); end
    n_cmp++; if (hh_bcd !== 8'h00) begin n_bad++; $display("FAIL run_hh: got %h want 00", hh_bcd); end
  endtask

  task automatic test_rollover();
    do_reset();
    adj_mode = 1'b1;
    preset(23, 59);
    step(2);
    n_cmp++; if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h235900) begin n_bad++; $display("FAIL roll_preset: got %h want 235900", {hh_bcd, mm_bcd, ss_bcd}); end
    adj_mode = 1'b0;
    for (int i = 1; i <= 240; i++) begin
      step(1);
      if (i == 239) begin
        n_cmp++; if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h235959) begin n_bad++; $display("FAIL roll_pre: got %h want 235959", {hh_bcd, mm_bcd, ss_bcd}); end
        n_cmp++; if (tick_1hz !== 1'b1 || hour_pulse !== 1'b0) begin n_bad++; $display("FAIL roll_pre_flags: got tick=%b hp=%b want tick=1 hp=0", tick_1hz, hour_pulse); end
      end
    end
    n_cmp++; if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000000) begin n_bad++; $display("FAIL roll_wrap: got %h want 000000", {hh_bcd, mm_bcd, ss_bcd}); end
    n_cmp++; if (hour_pulse !== 1'b1) begin n_bad++; $display("FAIL roll_hp: got %b want 1", hour_pulse); end
    step(1);
    n_cmp++; if (hour_pulse !== 1'b0) begin n_bad++; $display("FAIL roll_hp_end: got %b want 0", hour_pulse); end
  endtask

  task automatic test_adj_min_hold();
    do_reset();
    adj_mode = 1'b1;
    preset(1, 0);
    min_en = 1'b1;
    step(1);
    n_cmp++; if (mm_bcd !== 8'h00) begin n_bad++; $display("FAIL hold_lat1: got %h want 00", mm_bcd); end
    step(1);
    n_cmp++; if (mm_bcd !== 8'h01) begin n_bad++; $display("FAIL hold_lat2: got %h want 01", mm_bcd); end
    step(8);
    n_cmp++; if (mm_bcd !== 8'h01) begin n_bad++; $display("FAIL hold_once: got %h want 01", mm_bcd); end
    min_en = 1'b0;
    step(1);
    preset(0, 58);
    step(1);
    n_cmp++; if (mm_bcd !== 8'h59) begin n_bad++; $display("FAIL hold_mm59: got %h want 59", mm_bcd); end
    preset(0, 1);
    step(1);
    n_cmp++; if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h010000) begin n_bad++; $display("FAIL hold_nocarry: got %h want 010000", {hh_bcd, mm_bcd, ss_bcd}); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    adj_mode = 1'b1;
    preset(10, 20);
    step(1);
    n_cmp++; if ({hh_bcd, mm_bcd} !== 16'h1020) begin n_bad++; $display("FAIL sim_preset: got %h want 1020", {hh_bcd, mm_bcd}); end
    hour_en = 1'b1; min_en = 1'b1;
    step(1);
    n_cmp++; if ({hh_bcd, mm_bcd} !== 16'h1020) begin n_bad++; $display("FAIL sim_lat1: got %h want 1020", {hh_bcd, mm_bcd}); end
    step(1);
    n_cmp++; if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h112100) begin n_bad++; $display("FAIL sim_both: got %h want 112100", {hh_bcd, mm_bcd, ss_bcd}); end
    hour_en = 1'b0; min_en = 1'b0;
    step(1);
  endtask

  task automatic test_run_ignore();
    do_reset();
    preset(5, 5);
    n_cmp++; if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000002) begin n_bad++; $display("FAIL ign_run: got %h want 000002", {hh_bcd, mm_bcd, ss_bcd}); end
    step(1);
    n_cmp++; if (tick_1hz !== 1'b1) begin n_bad++; $display("FAIL ign_tick: got %b want 1", tick_1hz); end
    adj_mode = 1'b1;
    #1;
    n_cmp++; if (tick_1hz !== 1'b0) begin n_bad++; $display("FAIL ign_tick_supp: got %b want 0", tick_1hz); end
    step(1);
    n_cmp++; if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000000) begin n_bad++; $display("FAIL ign_adj_clr: got %h want 000000", {hh_bcd, mm_bcd, ss_bcd}); end
    step(3);
    n_cmp++; if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000000) begin n_bad++; $display("FAIL ign_noqueue: got %h want 000000", {hh_bcd, mm_bcd, ss_bcd}); end
    n_cmp++; if (tick_1hz !== 1'b0 || hour_pulse !== 1'b0) begin n_bad++; $display("FAIL ign_adj_flags: got tick=%b hp=%b want 0 0", tick_1hz, hour_pulse); end
    adj_mode = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      n_cmp++;
      if (tick_1hz !== (i == 3)) begin n_bad++; $display("FAIL ign_resume_tick[%0d]: got %b want %b", i, tick_1hz, (i == 3)); end
    end
    n_cmp++; if (ss_bcd !== 8'h01) begin n_bad++; $display("FAIL ign_resume_ss: got %h want 01", ss_bcd); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    adj_mode = 1'b1;
    preset(12, 34);
    step(1);
    adj_mode = 1'b0;
    step(224);
    n_cmp++; if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h123456) begin n_bad++; $display("FAIL mid_time: got %h want 123456", {hh_bcd, mm_bcd, ss_bcd}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({hh_bcd, mm_bcd, ss_bcd} !== 24'h000000) begin n_bad++; $display("FAIL mid_async: got %h want 000000", {hh_bcd, mm_bcd, ss_bcd}); end
    step(1);
    rst_n = 1'b1;
    step(3);
    n_cmp++; if (tick_1hz !== 1'b1 || ss_bcd !== 8'h00) begin n_bad++; $display("FAIL mid_first_tick: got tick=%b ss=%h want 1 00", tick_1hz, ss_bcd); end
    step(1);
    n_cmp++; if (ss_bcd !== 8'h01 || tick_1hz !== 1'b0) begin n_bad++; $display("FAIL mid_ss: got ss=%h tick=%b want 01 0", ss_bcd, tick_1hz); end
  endtask

  task automatic test_reset_edge();
    rst_n = 1'b0; adj_mode = 1'b1; hour_en = 1'b1; min_en = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(1);
    n_cmp++; if ({hh_bcd, mm_bcd} !== 16'h0000) begin n_bad++; $display("FAIL redge_lat: got %h want 0000", {hh_bcd, mm_bcd}); end
    step(1);
    n_cmp++; if ({hh_bcd, mm_bcd} !== 16'h0101) begin n_bad++; $display("FAIL redge_count: got %h want 0101", {hh_bcd, mm_bcd}); end
    step(3);
    n_cmp++; if ({hh_bcd, mm_bcd} !== 16'h0101) begin n_bad++; $display("FAIL redge_once: got %h want 0101", {hh_bcd, mm_bcd}); end
    hour_en = 1'b0; min_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_rollover();
    test_adj_min_hold();
    test_simultaneous();
    test_run_ignore();
    test_reset_mid();
    test_reset_edge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100, giving clk cycles per 1 s tick (legal range 2..1023).
REQ-002 SHALL have port clk, input, 1, the single system clock (CP2, 100 Hz nominal); every register is clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port adj_mode, input, 1, adjust mode (K0): 1 = adjust, 0 = run; synchronous to clk.
REQ-005 SHALL have port hour_en, input, 1, hour +1 request; synchronous to clk.
REQ-006 SHALL have port min_en, input, 1, minute +1 request; synchronous to clk.
REQ-007 SHALL have port hh_bcd, output, 8, hours as two BCD digits, tens in [7:4], range 00..23.
REQ-008 SHALL have port mm_bcd, output, 8, minutes as two BCD digits, range 00..59.
REQ-009 SHALL have port ss_bcd, output, 8, seconds as two BCD digits, range 00..59.
REQ-010 SHALL have port tick_1hz, output, 1, one-cycle pulse on every prescaler terminal count.
REQ-011 SHALL have port hour_pulse, output, 1, one-cycle pulse when minutes wrap 59->00 in run mode.

Function
REQ-012 Prescaler SHALL count 0..CLK_DIV-1 and wrap.
REQ-013 tick_1hz SHALL be high for exactly the cycle in which the prescaler equals CLK_DIV-1 and adj_mode=0.
REQ-014 Run mode: on each tick, ss SHALL increment; on 59 it SHALL wrap to 00 and carry into mm.
REQ-015 mm SHALL increment on carry; on 59 it SHALL wrap to 00, carry into hh, and pulse hour_pulse in the same cycle as the update.
REQ-016 hh SHALL increment on carry; 23 SHALL wrap to 00.
REQ-017 Full rollover 23:59:59 -> 00:00:00 SHALL complete in one cycle.
REQ-018 BCD digits SHALL be kept directly, with no binary-to-BCD conversion; every nibble SHALL stay in 0..9 at all times.
REQ-019 hour_en and min_en SHALL each be registered one stage.
REQ-020 An increment SHALL occur only on a rising edge (input=1, registered copy=0), so a level held for N cycles counts once.
REQ-021 Adjust mode: a min_en rising edge SHALL set mm := (mm+1) mod 60, with no carry to hh.
REQ-022 Adjust mode: an hour_en rising edge SHALL set hh := (hh+1) mod 24.
REQ-023 Adjusted values SHALL be visible on the outputs 2 cycles after the input rises (1 cycle edge register, 1 cycle update).
REQ-024 Simultaneous hour_en and min_en edges SHALL both apply in the same cycle.
REQ-025 Adjust mode SHALL clear ss to 00 and hold it there.
REQ-026 Adjust mode SHALL hold the prescaler at 0.
REQ-027 Adjust mode SHALL suppress tick_1hz and hour_pulse.
REQ-028 Run mode SHALL ignore hour_en and min_en; edges arriving while adj_mode=0 SHALL be discarded, not queued.
REQ-029 On an adj_mode 1->0 transition, counting SHALL resume with the prescaler at 0, and the first tick SHALL come CLK_DIV cycles later.
REQ-030 On an adj_mode 0->1 transition in the same cycle as a tick, the tick SHALL be suppressed and ss SHALL go to 00.

Reset
REQ-031 rst_n=0 SHALL immediately set hh_bcd=8'h00, mm_bcd=8'h00, ss_bcd=8'h00, tick_1hz=0, hour_pulse=0, prescaler=0, and both edge registers=0.
REQ-032 After rst_n releases, a hour_en or min_en input already high SHALL count as one rising edge.
REQ-033 Assertion of rst_n in any cycle, including mid-rollover or mid-adjust, SHALL override all other activity.

Verification (CLK_DIV=4)
REQ-034 Bench SHALL cover reset then run 60 ticks (240 cycles): ss 00->59->00, mm=01, a single hour_pulse of 0, and tick_1hz every 4th cycle.
REQ-035 Bench SHALL cover preload by adjust to 23:59, adj_mode=0, then 60 ticks: 23:59:59 -> 00:00:00 in one cycle, with hour_pulse=1 for that cycle.
REQ-036 Bench SHALL cover adj_mode=1 with min_en held high 10 cycles: mm +1 only; with mm=59, a min_en edge gives mm=00 and hh unchanged.
REQ-037 Bench SHALL cover adj_mode=1 with hour_en and min_en rising in the same cycle from 10:20: 11:21:00 appears 2 cycles later.
REQ-038 Bench SHALL cover adj_mode=0 with 5 hour_en pulses: time advances only by ticks, and no increment appears after a later switch to adjust.
REQ-039 Bench SHALL cover rst_n asserted for 1 cycle mid-count at 12:34:56: all outputs 00 asynchronously, and the first tick comes 4 cycles after release.
